// File: rtl/ascon_absorb_engine.sv
// ascon_absorb_engine
// Multi-cycle Ascon absorb engine. Takes rate-sized blocks over a valid/ready
// handshake, applies padding and domain separation, and steps an external
// one-round permutation unit ROUNDS times per block.

module ascon_absorb_engine #(
   parameter int RATE_BYTES    = 16,
   parameter int ROUNDS        = 8,
   parameter bit FINAL_PERMUTE = 1'b1,
   parameter bit DOMAIN_SEP    = 1'b1,
   parameter bit EMPTY_SKIP    = 1'b1,
   parameter int BW            = $clog2(RATE_BYTES + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    empty_i,
   input  logic                    abort,
   input  logic [319:0]            state_i,
   input  logic                    msg_valid,
   output logic                    msg_ready,
   input  logic [8*RATE_BYTES-1:0] msg_data,
   input  logic [BW-1:0]           msg_bytes,
   input  logic                    msg_last,
   output logic [319:0]            perm_state_o,
   output logic [3:0]              perm_round_o,
   input  logic [319:0]            perm_state_i,
   output logic [319:0]            state_o,
   output logic                    busy,
   output logic                    done,
   output logic [31:0]             blk_cnt
);

   localparam int             LANES      = RATE_BYTES / 8;
   localparam int             DW         = 8 * RATE_BYTES;
   localparam logic [3:0]     ROUND_BASE = 4'(12 - ROUNDS);
   localparam logic [3:0]     ROUND_LAST = 4'(ROUNDS - 1);
   localparam logic [DW-1:0]  PAD_ONE    = DW'(8'h01);

   typedef enum logic [2:0] {
      IDLE, WAIT_BLK, PERMUTE, PAD_BLK, FINAL, DONE
   } state_t;

   state_t         r_fsm;
   state_t         w_fsmNext;
   state_t         r_succ;
   state_t         w_succAfterBlk;
   logic [319:0]   r_state;
   logic [31:0]    r_blkCnt;
   logic [3:0]     r_round;
   logic           w_accept;
   logic           w_fullLast;
   logic           w_lastRound;
   logic [DW-1:0]  w_padVec;
   logic [319:0]   w_absorb;

   // A last block claiming RATE_BYTES or more is treated as full and gets a separate pad block
   assign w_fullLast  = (int'(msg_bytes) >= RATE_BYTES);
   assign w_lastRound = (r_round == ROUND_LAST);
   assign w_accept    = msg_valid && msg_ready;

   assign perm_state_o = r_state;
   assign state_o      = r_state;
   assign perm_round_o = ROUND_BASE + r_round;
   assign blk_cnt      = r_blkCnt;

   // Build the value XORed into the state: data lane k goes to x_k, plus the inline pad byte
   always_comb begin
      w_padVec = '0;
      if (msg_last && !w_fullLast)
         w_padVec = PAD_ONE << {msg_bytes, 3'b000};
      w_absorb = '0;
      for (int k = 0; k < LANES; k++)
         w_absorb[319-64*k -: 64] = msg_data[64*k +: 64] ^ w_padVec[64*k +: 64];
      if (!msg_last)
         w_succAfterBlk = WAIT_BLK;
      else if (w_fullLast)
         w_succAfterBlk = PAD_BLK;
      else
         w_succAfterBlk = FINAL;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_fsm <= IDLE;
      else
         r_fsm <= w_fsmNext;
   end

   // Next-state logic; abort overrides every other transition
   always_comb begin
      w_fsmNext = r_fsm;
      if (abort) begin
         w_fsmNext = IDLE;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (start) begin
                  if (!empty_i)
                     w_fsmNext = WAIT_BLK;
                  else if (EMPTY_SKIP)
                     w_fsmNext = FINAL;
                  else
                     w_fsmNext = PAD_BLK;
               end
            end
            WAIT_BLK: begin
               if (w_accept) begin
                  if (!msg_last || w_fullLast || FINAL_PERMUTE)
                     w_fsmNext = PERMUTE;
                  else
                     w_fsmNext = FINAL;
               end
            end
            PERMUTE:  if (w_lastRound) w_fsmNext = r_succ;
            PAD_BLK:  w_fsmNext = FINAL_PERMUTE ? PERMUTE : FINAL;
            FINAL:    w_fsmNext = DONE;
            DONE:     w_fsmNext = IDLE;
            default:  w_fsmNext = IDLE;
         endcase
      end
   end

   // Moore outputs; ready drops while abort is pending so nothing is consumed on that edge
   always_comb begin
      msg_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (r_fsm)
         IDLE:     busy = 1'b0;
         WAIT_BLK: begin
            busy      = 1'b1;
            msg_ready = !abort;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default:  busy = 1'b1;
      endcase
   end

   // Datapath: state register, block counter, round counter and post-permute successor
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= '0;
         r_blkCnt <= '0;
         r_round  <= '0;
         r_succ   <= IDLE;
      end else if (abort) begin
         r_round <= '0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (start) begin
                  r_state  <= state_i;
                  r_blkCnt <= '0;
               end
            end
            WAIT_BLK: begin
               if (w_accept) begin
                  r_state  <= r_state ^ w_absorb;
                  r_blkCnt <= r_blkCnt + 32'd1;
                  r_succ   <= w_succAfterBlk;
               end
            end
            PAD_BLK: begin
               r_state[263:256] <= r_state[263:256] ^ 8'h01;
               r_blkCnt         <= r_blkCnt + 32'd1;
               r_succ           <= FINAL;
            end
            PERMUTE: begin
               r_state <= perm_state_i;
               r_round <= w_lastRound ? 4'd0 : r_round + 4'd1;
            end
            FINAL: begin
               if (DOMAIN_SEP)
                  r_state[63] <= ~r_state[63];
            end
            default: begin
               r_round <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ascon_absorb_engine.sv
// tb_ascon_absorb_engine
// Drives two engine configurations (AEAD-style rate 16 / p8 and hash-style
// rate 8 / p12) with directed and random messages and compares against a
// message-level reference model of padding, rounds and domain separation.

module tb_ascon_absorb_engine;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, emptyIn, abortIn, msgValid, msgLast;
   logic          sel, identStub;
   logic [319:0]  stateIn;
   logic [127:0]  msgData;
   logic [4:0]    msgBytes;

   logic          readyA, busyA, doneA, readyB, busyB, doneB;
   logic [319:0]  permOutA, permInA, stateOutA, permOutB, permInB, stateOutB;
   logic [3:0]    roundA, roundB;
   logic [31:0]   cntA, cntB;

   logic          wReady, wBusy, wDone;
   logic [319:0]  wStateOut;
   logic [3:0]    wRound;
   logic [31:0]   wCnt;

   logic [127:0]  blkData [8];
   int            cyc = 0;
   int            readyCnt = 0;
   int            testCount = 0;
   int            failCount = 0;

   always #5 clk = ~clk;

   // Free-running cycle counter and a count of cycles with msg_ready high
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (wReady) readyCnt <= readyCnt + 1;

   // Round-unit stand-in: identity, or rotate-by-one with the round index folded into x2
   function automatic logic [319:0] stubRound(input logic [319:0] s, input logic [3:0] rc, input logic ident);
      if (ident) return s;
      return {s[318:0], s[319]} ^ ({316'd0, rc} << 128);
   endfunction

   assign permInA = stubRound(permOutA, roundA, identStub);
   assign permInB = stubRound(permOutB, roundB, identStub);

   assign wReady    = sel ? readyB    : readyA;
   assign wBusy     = sel ? busyB     : busyA;
   assign wDone     = sel ? doneB     : doneA;
   assign wStateOut = sel ? stateOutB : stateOutA;
   assign wRound    = sel ? roundB    : roundA;
   assign wCnt      = sel ? cntB      : cntA;

   ascon_absorb_engine #(.RATE_BYTES(16), .ROUNDS(8), .FINAL_PERMUTE(1'b1),
                         .DOMAIN_SEP(1'b1), .EMPTY_SKIP(1'b1)) dutA (
      .clk(clk), .rst_n(rst_n), .start(start & ~sel), .empty_i(emptyIn),
      .abort(abortIn & ~sel), .state_i(stateIn), .msg_valid(msgValid & ~sel),
      .msg_ready(readyA), .msg_data(msgData), .msg_bytes(msgBytes),
      .msg_last(msgLast), .perm_state_o(permOutA), .perm_round_o(roundA),
      .perm_state_i(permInA), .state_o(stateOutA), .busy(busyA), .done(doneA),
      .blk_cnt(cntA));

   ascon_absorb_engine #(.RATE_BYTES(8), .ROUNDS(12), .FINAL_PERMUTE(1'b1),
                         .DOMAIN_SEP(1'b0), .EMPTY_SKIP(1'b0)) dutB (
      .clk(clk), .rst_n(rst_n), .start(start & sel), .empty_i(emptyIn),
      .abort(abortIn & sel), .state_i(stateIn), .msg_valid(msgValid & sel),
      .msg_ready(readyB), .msg_data(msgData[63:0]), .msg_bytes(msgBytes[3:0]),
      .msg_last(msgLast), .perm_state_o(permOutB), .perm_round_o(roundB),
      .perm_state_i(permInB), .state_o(stateOutB), .busy(busyB), .done(doneB),
      .blk_cnt(cntB));

   function automatic logic [319:0] rand320();
      logic [319:0] r = '0;
      for (int i = 0; i < 10; i++) r = {r[287:0], $urandom()};
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Block byte j lives in lane j/8 (x_{j/8}), little-endian inside the lane
   function automatic logic [319:0] xorByte(input logic [319:0] s, input int j, input logic [7:0] b);
      logic [319:0] r = s;
      int pos = 256 - 64 * (j / 8) + 8 * (j % 8);
      r[pos +: 8] = r[pos +: 8] ^ b;
      return r;
   endfunction

   function automatic logic [319:0] permute(input logic [319:0] s, input int nr);
      logic [319:0] r = s;
      for (int i = 0; i < nr; i++) r = stubRound(r, 4'(12 - nr + i), identStub);
      return r;
   endfunction

   // Reference: absorb a whole message of nBlk blocks (0 = empty input)
   task automatic modelRun(input bit selB, input logic [319:0] init, input int nBlk,
                           input int lastBytes, output logic [319:0] expS, output int expCnt);
      int rate = selB ? 8 : 16;
      int nr   = selB ? 12 : 8;
      bit es   = !selB;
      bit ds   = !selB;
      logic [319:0] s = init;
      expCnt = 0;
      if (nBlk == 0) begin
         if (!es) begin
            s = xorByte(s, 0, 8'h01);
            expCnt = 1;
            s = permute(s, nr);
         end
      end else begin
         for (int i = 0; i < nBlk; i++) begin
            for (int j = 0; j < rate; j++) s = xorByte(s, j, blkData[i][8*j +: 8]);
            expCnt++;
            if (i < nBlk - 1) begin
               s = permute(s, nr);
            end else if (lastBytes < rate) begin
               s = xorByte(s, lastBytes, 8'h01);
               s = permute(s, nr);
            end else begin
               s = permute(s, nr);
               s = xorByte(s, 0, 8'h01);
               expCnt++;
               s = permute(s, nr);
            end
         end
      end
      if (ds) s[63] = ~s[63];
      expS = s;
   endtask

   task automatic checkOutput(input string tag, input logic [319:0] got, input logic [319:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Run one message through the selected engine; entered and left on a falling edge
   task automatic applyStimulus(input bit selB, input logic [319:0] init, input int nBlk,
                                input int lastBytes, input int maxGap,
                                output int startCyc, output int acceptCyc, output int doneCyc);
      int nr = selB ? 12 : 8;
      int w;
      sel = selB;
      stateIn = init;
      emptyIn = (nBlk == 0);
      start = 1'b1;
      startCyc = cyc;
      acceptCyc = 0;
      doneCyc = 0;
      @(negedge clk);
      start = 1'b0;
      stateIn = rand320();
      if (nBlk == 0 && selB) begin
         @(negedge clk);
         for (int r = 0; r < nr; r++) begin
            checkOutput("emptyRound", 320'(wRound), 320'(12 - nr + r));
            checkOutput("emptyRdy", 320'(wReady), 320'd0);
            @(negedge clk);
         end
      end
      for (int i = 0; i < nBlk; i++) begin
         msgValid = 1'b1;
         msgData = blkData[i];
         msgLast = (i == nBlk - 1);
         msgBytes = (i == nBlk - 1) ? 5'(lastBytes) : 5'($urandom());
         w = 0;
         while (!wReady && w < 200) begin
            @(negedge clk);
            w++;
         end
         if (w >= 200) begin
            checkOutput("readyTimeout", 320'd1, 320'd0);
            msgValid = 1'b0;
            return;
         end
         acceptCyc = cyc;
         @(negedge clk);
         for (int r = 0; r < nr; r++) begin
            msgValid = 1'($urandom());
            msgData = rand128();
            msgLast = 1'($urandom());
            start = 1'($urandom());
            checkOutput("permRound", 320'(wRound), 320'(12 - nr + r));
            checkOutput("permRdy", 320'(wReady), 320'd0);
            @(negedge clk);
         end
         start = 1'b0;
         msgValid = 1'b0;
         msgLast = 1'b0;
         if (i < nBlk - 1) repeat ($urandom_range(0, maxGap)) @(negedge clk);
      end
      w = 0;
      while (!wDone && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) begin
         checkOutput("doneTimeout", 320'd1, 320'd0);
         return;
      end
      doneCyc = cyc;
      @(negedge clk);
      checkOutput("donePulse", 320'(wDone), 320'd0);
      checkOutput("idleBusy", 320'(wBusy), 320'd0);
   endtask

   task automatic runChecked(input string tag, input bit selB, input int nBlk,
                             input int lastBytes, input int maxGap);
      logic [319:0] s, expS;
      int expCnt, sc, ac, dc;
      s = rand320();
      for (int i = 0; i < nBlk; i++) blkData[i] = rand128();
      modelRun(selB, s, nBlk, lastBytes, expS, expCnt);
      applyStimulus(selB, s, nBlk, lastBytes, maxGap, sc, ac, dc);
      checkOutput({tag, "State"}, wStateOut, expS);
      checkOutput({tag, "Cnt"}, 320'(wCnt), 320'(expCnt));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [319:0] s, expS;
      int expCnt, sc, ac, dc, rdyBefore, doneSeen, w;

      rst_n = 1'b0;
      start = 1'b0; emptyIn = 1'b0; abortIn = 1'b0; msgValid = 1'b0; msgLast = 1'b0;
      sel = 1'b0; identStub = 1'b1; stateIn = '0; msgData = '0; msgBytes = '0;
      repeat (3) @(negedge clk);
      checkOutput("rstBusyA", 320'(busyA), 320'd0);
      checkOutput("rstReadyA", 320'(readyA), 320'd0);
      checkOutput("rstDoneA", 320'(doneA), 320'd0);
      checkOutput("rstStateA", stateOutA, 320'd0);
      checkOutput("rstCntA", 320'(cntA), 320'd0);
      checkOutput("rstRoundA", 320'(roundA), 320'd4);
      checkOutput("rstRoundB", 320'(roundB), 320'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Empty AEAD input: only domain separation
      s = rand320();
      rdyBefore = readyCnt;
      modelRun(1'b0, s, 0, 0, expS, expCnt);
      applyStimulus(1'b0, s, 0, 0, 0, sc, ac, dc);
      checkOutput("emptyLat", 320'(dc - sc), 320'd2);
      checkOutput("emptyState", stateOutA, s ^ {256'd0, 64'h8000_0000_0000_0000});
      checkOutput("emptyModel", stateOutA, expS);
      checkOutput("emptyCnt", 320'(cntA), 320'd0);
      checkOutput("emptyNoRdy", 320'(readyCnt - rdyBefore), 320'd0);

      // Short last block, identity rounds
      s = rand320();
      blkData[0] = 128'h00CC_BBAA;
      applyStimulus(1'b0, s, 1, 3, 0, sc, ac, dc);
      checkOutput("shortLat", 320'(dc - ac), 320'd10);
      checkOutput("shortState", stateOutA,
                  s ^ {64'h0000_0000_01CC_BBAA, 192'd0, 64'h8000_0000_0000_0000});
      checkOutput("shortCnt", 320'(cntA), 320'd1);

      // Full last block, identity rounds: extra pad block
      s = rand320();
      blkData[0] = rand128();
      applyStimulus(1'b0, s, 1, 16, 0, sc, ac, dc);
      checkOutput("fullLat", 320'(dc - ac), 320'd19);
      checkOutput("fullState", stateOutA,
                  s ^ {blkData[0][63:0] ^ 64'h1, blkData[0][127:64], 128'd0, 64'h8000_0000_0000_0000});
      checkOutput("fullCnt", 320'(cntA), 320'd2);

      // Empty hash input: padding-only block, no domain separation
      s = rand320();
      applyStimulus(1'b1, s, 0, 0, 0, sc, ac, dc);
      checkOutput("hashEmptyState", stateOutB, s ^ (320'd1 << 256));
      checkOutput("hashEmptyX4", 320'(stateOutB[63:0]), 320'(s[63:0]));
      checkOutput("hashEmptyCnt", 320'(cntB), 320'd1);

      // Multi-block messages with valid gaps, real round function
      identStub = 1'b0;
      runChecked("gapsA", 1'b0, 4, $urandom_range(0, 15), 3);
      runChecked("gapsFullA", 1'b0, 4, 16, 3);
      runChecked("gapsB", 1'b1, 4, $urandom_range(0, 7), 3);
      runChecked("gapsFullB", 1'b1, 3, 12, 2);
      runChecked("hashEmptyRnd", 1'b1, 0, 0, 0);

      // Abort in the third permutation cycle
      identStub = 1'b1;
      sel = 1'b0;
      s = rand320();
      blkData[0] = rand128();
      stateIn = s; emptyIn = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      msgValid = 1'b1; msgData = blkData[0]; msgLast = 1'b0;
      w = 0;
      while (!readyA && w < 50) begin
         @(negedge clk);
         w++;
      end
      checkOutput("abortRdyWait", 320'(w < 50), 320'd1);
      @(negedge clk);
      msgValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("abortRound", 320'(roundA), 320'd6);
      abortIn = 1'b1;
      @(negedge clk);
      abortIn = 1'b0;
      checkOutput("abortBusy", 320'(busyA), 320'd0);
      checkOutput("abortState", stateOutA, s ^ {blkData[0][63:0], blkData[0][127:64], 192'd0});
      checkOutput("abortCnt", 320'(cntA), 320'd1);
      doneSeen = 0;
      repeat (15) begin
         if (doneA) doneSeen++;
         @(negedge clk);
      end
      checkOutput("abortNoDone", 320'(doneSeen), 320'd0);
      identStub = 1'b0;
      runChecked("afterAbort", 1'b0, 2, $urandom_range(0, 16), 1);

      // Reset in the middle of a permutation
      sel = 1'b0;
      stateIn = rand320(); emptyIn = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      msgValid = 1'b1; msgData = rand128(); msgLast = 1'b0;
      @(negedge clk);
      msgValid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midRstState", stateOutA, 320'd0);
      checkOutput("midRstCnt", 320'(cntA), 320'd0);
      checkOutput("midRstBusy", 320'(busyA), 320'd0);
      checkOutput("midRstReady", 320'(readyA), 320'd0);
      checkOutput("midRstDone", 320'(doneA), 320'd0);
      checkOutput("midRstRound", 320'(roundA), 320'd4);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      runChecked("afterRst", 1'b0, 1, $urandom_range(0, 16), 0);

      // Random messages on both configurations
      for (int n = 0; n < 40; n++) begin
         bit selB;
         int nBlk, lb;
         selB = 1'($urandom());
         nBlk = $urandom_range(0, 3);
         lb = $urandom_range(0, 3) == 0 ? (selB ? 8 : 16) : $urandom_range(0, selB ? 15 : 31);
         runChecked("rnd", selB, nBlk, lb, 2);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
